host_bus_bridge: RTL and testbench
==================================

# host_bus_bridge

- Bridges the external host's asynchronous static-memory bus (chip select, read and write strobes, wait) onto the internal single-cycle peripheral register bus.
- It is the initiator for that bus: it drives address, write data, enable and read/write strobes, and captures read data from register-bus responders such as the GPIO block.
- Sits between the FPGA host pins and the address decode/peripheral fan-out.
- Runs entirely on the FPGA clock; host strobes are synchronized internally.

## Interface
Parameters:
- ADDR_W, 8, register-bus address width (host address width identical)
- DATA_W, 16, data width of host and register bus

Ports:
- Clk  in  1  system clock; all state on rising edge
- RstN  in  1  asynchronous active-low reset
- HCsN  in  1  host chip select, active low, asynchronous to Clk
- HRdN  in  1  host read strobe, active low, asynchronous
- HWrN  in  1  host write strobe, active low, asynchronous
- HAddr  in  ADDR_W  host address, stable while the strobe is active
- HDataIn  in  DATA_W  host write data, stable while HWrN is low
- HDataOut  out  DATA_W  read data returned to host
- HDataOe  out  1  pad output enable for HDataOut
- HWait  out  1  active-high wait to host
- Addr  out  ADDR_W  register-bus address
- DataWr  out  DATA_W  register-bus write data
- DataRd  in  DATA_W  register-bus read data; combinational from responder
- En  out  1  register-bus transaction enable
- Rd  out  1  register-bus read qualifier
- Wr  out  1  register-bus write qualifier
- Err  out  1  sticky protocol-error flag

## Operation
- **Synchronization:** HCsN, HRdN and HWrN each pass through 2 flops. The synced read request is rd_s = !cs & !rd & wr. The synced write request is wr_s = !cs & !wr & rd.
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - rd_s or wr_s high: latch HAddr into Addr. For a write, also latch HDataIn into DataWr. Record direction. Go to ACCESS.
  - Synced cs, rd and wr all low (both strobes): set Err and stay in IDLE. No bus transaction occurs.
- **ACCESS:**
  - Lasts exactly one cycle: En=1, with Rd=1 for a read or Wr=1 for a write.
  - For a read, DataRd is registered into HDataOut at the end of the cycle.
  - Next state is DONE.
- **DONE:**
  - En, Rd and Wr are 0. The internal done flag is 1.
  - Stay in DONE while the synced strobe of the recorded direction and cs are still active.
  - Return to IDLE, clearing done, once either deasserts.
- **Outputs:**
  - HWait = RstN & !HCsN & (!HRdN ^ !HWrN) & !done. It uses raw pins, so wait asserts combinationally as soon as the host strobes.
  - HDataOe = RstN & !HCsN & !HRdN & HWrN, combinational from raw pins.
  - HDataOut holds its last captured value; it is meaningful only once HWait is low.
- **Err:** sticky, cleared only by reset.
- **One transaction per assertion:** a strobe held low indefinitely produces exactly one En pulse.
- **Host constraints:**
  - Strobes stay deasserted ≥ 3 Clk between accesses, so done clears before the next strobe.
  - HAddr and HDataIn are stable from strobe assertion until HWait falls.

## Timing
- **Reset values:** state IDLE, En=Rd=Wr=0, Addr=0, DataWr=0, HDataOut=0, Err=0, done=0, synchronizers at 1 (inactive). HWait=0 and HDataOe=0 while RstN is low.
- **Reset mid-transaction:** any in-flight access is abandoned; no En pulse is issued after RstN falls. After RstN rises with the strobe still low, the bridge re-synchronizes and executes the access once.
- **Latency:**
  - Strobe falls, then the synced request is seen at edge k, where k is 2–3 edges after the strobe.
  - En is high in cycle k→k+1.
  - Write is committed, or read data captured, at edge k+1.
  - HWait falls after edge k+1.
  - Total strobe-to-HWait-low: 3–4 Clk.
- **Release:** return to IDLE 2–3 Clk after the strobe rises.
- **Throughput:** minimum 6 Clk per host access.
- **Ordering:** back-to-back read-after-write to the same address returns the written value, because the write commits before the read's ACCESS cycle.

## Test plan
- **Write:** reset, then HCsN=0, HWrN=0, HAddr=0x02, HDataIn=0xA5C3. Required: one cycle with En=1, Wr=1, Rd=0, Addr=0x02, DataWr=0xA5C3. HWait rises immediately and falls 3–4 Clk later. Release strobes; FSM is in IDLE within 3 Clk.
- **Read:** responder model returns 0x1234 when Addr=0x03. Read of 0x03 gives one En=1, Rd=1 cycle; HDataOe=1 throughout the strobe; HDataOut=0x1234 when HWait falls.
- **Hold:** keep HWrN low for 50 Clk. Required: exactly one En pulse, and HWait stays low after completion.
- **Protocol error:** HRdN and HWrN both low with HCsN low. Required: no En pulse, HWait=0, Err=1 and still 1 after a subsequent valid access.
- **Reset during access:** assert RstN=0 on the cycle after the strobe falls, hold 2 Clk, release with the strobe still low. Required: all outputs at reset values during reset, then exactly one En pulse after release.
- **Randomized traffic:** 1000 random reads and writes with a random Clk phase and ≥ 3 Clk gaps, checked against a scoreboard memory. No lost or duplicated transactions, and all read data matches.

Source files
------------

// File: rtl/host_bus_bridge.sv
// Host static-memory bus to internal register bus bridge.
// Host strobes are synchronized; each strobe assertion yields exactly one register-bus access.
module host_bus_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              HCsN,
    input  logic              HRdN,
    input  logic              HWrN,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [DATA_W-1:0] HDataIn,
    output logic [DATA_W-1:0] HDataOut,
    output logic              HDataOe,
    output logic              HWait,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] DataWr,
    input  logic [DATA_W-1:0] DataRd,
    output logic              En,
    output logic              Rd,
    output logic              Wr,
    output logic              Err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

    // Bit order in the synchronizer vectors: {wr, rd, cs}
    logic [2:0] strobeMeta;
    logic [2:0] strobeSync;

    stateT             stateReg, stateNext;
    logic              isWrReg, isWrNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [DATA_W-1:0] dataWrReg, dataWrNext;
    logic [DATA_W-1:0] hDataOutReg, hDataOutNext;
    logic              errReg, errNext;

    logic csS, rdS, wrS;
    logic rdReq, wrReq, bothReq, strobeHeld, done;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            strobeMeta <= 3'b111;
            strobeSync <= 3'b111;
        end else begin
            strobeMeta <= {HWrN, HRdN, HCsN};
            strobeSync <= strobeMeta;
        end
    end

    assign csS = strobeSync[0];
    assign rdS = strobeSync[1];
    assign wrS = strobeSync[2];

    assign rdReq   = !csS && !rdS && wrS;
    assign wrReq   = !csS && !wrS && rdS;
    assign bothReq = !csS && !rdS && !wrS;

    // The strobe of the recorded direction keeps the FSM parked in DONE
    assign strobeHeld = !csS && (isWrReg ? !wrS : !rdS);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            stateReg    <= IDLE;
            isWrReg     <= 1'b0;
            addrReg     <= '0;
            dataWrReg   <= '0;
            hDataOutReg <= '0;
            errReg      <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            isWrReg     <= isWrNext;
            addrReg     <= addrNext;
            dataWrReg   <= dataWrNext;
            hDataOutReg <= hDataOutNext;
            errReg      <= errNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        isWrNext     = isWrReg;
        addrNext     = addrReg;
        dataWrNext   = dataWrReg;
        hDataOutNext = hDataOutReg;
        errNext      = errReg;
        unique case (stateReg)
            IDLE: begin
                if (rdReq || wrReq) begin
                    addrNext = HAddr;
                    if (wrReq) begin
                        dataWrNext = HDataIn;
                    end
                    isWrNext  = wrReq;
                    stateNext = ACCESS;
                end else if (bothReq) begin
                    errNext = 1'b1;
                end
            end
            ACCESS: begin
                if (!isWrReg) begin
                    hDataOutNext = DataRd;
                end
                stateNext = DONE;
            end
            DONE: begin
                if (!strobeHeld) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign done = (stateReg == DONE);
    assign En   = (stateReg == ACCESS);
    assign Rd   = En && !isWrReg;
    assign Wr   = En && isWrReg;

    assign Addr     = addrReg;
    assign DataWr   = dataWrReg;
    assign HDataOut = hDataOutReg;
    assign Err      = errReg;

    // Raw pins so wait reaches the host before the synchronizers catch up
    assign HWait   = RstN && !HCsN && ((!HRdN) ^ (!HWrN)) && !done;
    assign HDataOe = RstN && !HCsN && !HRdN && HWrN;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed and scoreboarded traffic for host_bus_bridge with a register-bus memory responder.
module tb_host_bus_bridge;

    logic        Clk;
    logic        RstN;
    logic        HCsN, HRdN, HWrN;
    logic [7:0]  HAddr;
    logic [15:0] HDataIn;
    logic [15:0] HDataOut;
    logic        HDataOe, HWait;
    logic [7:0]  Addr;
    logic [15:0] DataWr, DataRd;
    logic        En, Rd, Wr, Err;

    host_bus_bridge #(.ADDR_W(8), .DATA_W(16)) dut (
        .Clk(Clk), .RstN(RstN), .HCsN(HCsN), .HRdN(HRdN), .HWrN(HWrN),
        .HAddr(HAddr), .HDataIn(HDataIn), .HDataOut(HDataOut), .HDataOe(HDataOe),
        .HWait(HWait), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
        .En(En), .Rd(Rd), .Wr(Wr), .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int assertCount = 0;
    int failCount   = 0;

    // Register-bus responder: combinational read, write on the enabled edge
    logic [15:0] respMem [256];
    bit          memInit = 1'b0;
    always @(posedge Clk) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++) respMem[i] <= (i == 3) ? 16'h1234 : 16'h0000;
            memInit <= 1'b1;
        end else if (En && Wr) begin
            respMem[Addr] <= DataWr;
        end
    end
    assign DataRd = respMem[Addr];

    // Bus monitor
    int          enCount  = 0;
    int          busViol  = 0;
    logic [7:0]  lastAddr = '0;
    logic [15:0] lastData = '0;
    logic        lastWr   = 1'b0;
    logic        lastRd   = 1'b0;
    always @(posedge Clk) begin
        if (En) begin
            enCount  <= enCount + 1;
            lastAddr <= Addr;
            lastData <= DataWr;
            lastWr   <= Wr;
            lastRd   <= Rd;
        end
        if (((Rd || Wr) && !En) || (En && (Rd == Wr))) busViol <= busViol + 1;
    end

    logic [15:0] refMem [256];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic hostAccess(input bit isWr, input logic [7:0] a, input logic [15:0] d,
                              input int holdCyc, output logic [15:0] rdata);
        int   en0;
        time  tStart, dt;
        bit   fell;
        bit   holdOk;
        @(posedge Clk);
        #($urandom_range(2, 8));
        en0     = enCount;
        HAddr   = a;
        HDataIn = d;
        HCsN    = 1'b0;
        if (isWr) HWrN = 1'b0;
        else      HRdN = 1'b0;
        tStart = $time;
        #1;
        check("hwait_rise", 32'(HWait), 1);
        check("hdataoe_level", 32'(HDataOe), 32'(!isWr));
        fell = 1'b0;
        for (int c = 0; c < 10 && !fell; c++) begin
            @(posedge Clk);
            #1;
            if (!HWait) fell = 1'b1;
        end
        check("hwait_fall", 32'(fell), 1);
        dt = $time - 1 - tStart;
        check("latency_3to4clk", 32'(dt >= 30 && dt <= 40), 1);
        check("en_pulses", 32'(enCount - en0), 1);
        check("bus_addr", 32'(lastAddr), 32'(a));
        check("bus_wr", 32'(lastWr), 32'(isWr));
        check("bus_rd", 32'(lastRd), 32'(!isWr));
        if (isWr) check("bus_wdata", 32'(lastData), 32'(d));
        rdata  = HDataOut;
        holdOk = 1'b1;
        for (int c = 0; c < holdCyc; c++) begin
            @(posedge Clk);
            #1;
            if (HWait || (HDataOe != !isWr)) holdOk = 1'b0;
        end
        if (holdCyc > 0) check("hold_hwait_low", 32'(holdOk), 1);
        HCsN = 1'b1;
        HRdN = 1'b1;
        HWrN = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("idle_after_release", 32'(dut.stateReg), 0);
        check("no_duplicate_en", 32'(enCount - en0), 1);
        repeat ($urandom_range(0, 2)) @(posedge Clk);
        $display("txn %s addr=0x%02h wdata=0x%04h rdata=0x%04h", isWr ? "WR" : "RD", a, d, rdata);
    endtask

    typedef struct {
        bit          isWr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expRd;
    } vecT;

    vecT vecs [10];

    task automatic checkResetOutputs(input string tag);
        check({tag, "_en"},       32'(En), 0);
        check({tag, "_rd"},       32'(Rd), 0);
        check({tag, "_wr"},       32'(Wr), 0);
        check({tag, "_addr"},     32'(Addr), 0);
        check({tag, "_datawr"},   32'(DataWr), 0);
        check({tag, "_hdataout"}, 32'(HDataOut), 0);
        check({tag, "_err"},      32'(Err), 0);
        check({tag, "_hwait"},    32'(HWait), 0);
        check({tag, "_hdataoe"},  32'(HDataOe), 0);
    endtask

    initial begin
        logic [15:0] rd;
        int          en0;
        bit          isWr;
        logic [7:0]  a;
        logic [15:0] d;

        vecs[0] = '{1'b1, 8'h02, 16'hA5C3, 16'h0000};
        vecs[1] = '{1'b0, 8'h03, 16'h0000, 16'h1234};
        vecs[2] = '{1'b0, 8'h02, 16'h0000, 16'hA5C3};
        vecs[3] = '{1'b1, 8'h03, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 8'h03, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 8'h00, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 8'hFF, 16'h8001, 16'h0000};
        vecs[7] = '{1'b0, 8'hFF, 16'h0000, 16'h8001};
        vecs[8] = '{1'b1, 8'h00, 16'h7E7E, 16'h0000};
        vecs[9] = '{1'b0, 8'h00, 16'h0000, 16'h7E7E};

        for (int i = 0; i < 256; i++) refMem[i] = (i == 3) ? 16'h1234 : 16'h0000;

        RstN = 1'b0; HCsN = 1'b1; HRdN = 1'b1; HWrN = 1'b1;
        HAddr = '0; HDataIn = '0;
        repeat (3) @(posedge Clk);
        #1;
        checkResetOutputs("reset");
        @(negedge Clk);
        RstN = 1'b1;
        repeat (2) @(posedge Clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            hostAccess(vecs[i].isWr, vecs[i].addr, vecs[i].wdata, 0, rd);
            if (vecs[i].isWr) refMem[vecs[i].addr] = vecs[i].wdata;
            else check("table_rdata", 32'(rd), 32'(vecs[i].expRd));
        end

        // Write strobe held for 50 cycles
        hostAccess(1'b1, 8'h20, 16'h5A5A, 50, rd);
        refMem[8'h20] = 16'h5A5A;
        hostAccess(1'b0, 8'h20, 16'h0000, 50, rd);
        check("hold_read_back", 32'(rd), 32'h5A5A);

        // Both strobes low: protocol error, no bus access
        @(posedge Clk);
        #3;
        en0 = enCount;
        HCsN = 1'b0; HRdN = 1'b0; HWrN = 1'b0;
        #1;
        check("proterr_hwait_now", 32'(HWait), 0);
        check("proterr_hdataoe", 32'(HDataOe), 0);
        repeat (6) @(posedge Clk);
        #1;
        check("proterr_no_en", 32'(enCount - en0), 0);
        check("proterr_hwait", 32'(HWait), 0);
        check("proterr_err", 32'(Err), 1);
        HCsN = 1'b1; HRdN = 1'b1; HWrN = 1'b1;
        repeat (4) @(posedge Clk);
        hostAccess(1'b0, 8'h02, 16'h0000, 0, rd);
        check("proterr_then_read", 32'(rd), 32'(refMem[8'h02]));
        check("err_sticky", 32'(Err), 1);

        // Reset one cycle after the strobe falls, released with the strobe still low
        @(posedge Clk);
        #3;
        en0 = enCount;
        HAddr = 8'h10; HDataIn = 16'h0BAD; HCsN = 1'b0; HWrN = 1'b0;
        @(posedge Clk);
        #1;
        RstN = 1'b0;
        #1;
        checkResetOutputs("midrst");
        repeat (2) @(posedge Clk);
        #1;
        checkResetOutputs("midrst_hold");
        check("midrst_no_en", 32'(enCount - en0), 0);
        @(negedge Clk);
        RstN = 1'b1;
        begin
            bit fell = 1'b0;
            for (int c = 0; c < 12 && !fell; c++) begin
                @(posedge Clk);
                #1;
                if (!HWait) fell = 1'b1;
            end
            check("midrst_hwait_fall", 32'(fell), 1);
        end
        check("midrst_one_en", 32'(enCount - en0), 1);
        check("midrst_addr", 32'(lastAddr), 32'h10);
        check("midrst_wdata", 32'(lastData), 32'h0BAD);
        HCsN = 1'b1; HWrN = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("midrst_still_one_en", 32'(enCount - en0), 1);
        refMem[8'h10] = 16'h0BAD;
        // After reset the responder still holds the earlier writes; scoreboard mirrors that

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            isWr = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 23));
            d    = 16'($urandom);
            hostAccess(isWr, a, d, 0, rd);
            if (isWr) refMem[a] = d;
            else check("rand_rdata", 32'(rd), 32'(refMem[a]));
        end

        check("bus_qualifier_violations", 32'(busViol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
